// File: rtl/fsk_tone_generator_if.sv
// Symbol handshake between a bit source and the FSK tone generator.
// The source drives bit_data/bit_valid; the generator answers with bit_ready.
// A symbol is consumed on every rising clock edge where bit_valid && bit_ready.
interface fsk_tone_generator_if;

   logic bit_data;
   logic bit_valid;
   logic bit_ready;

   // Bit source side
   modport master (
      output bit_data,
      output bit_valid,
      input  bit_ready
   );

   // Tone generator side
   modport slave (
      input  bit_data,
      input  bit_valid,
      output bit_ready
   );

endinterface

// File: rtl/fsk_tone_generator.sv
// fsk_tone_generator
// ------------------
// Serialises bits into a square-wave FSK stream. A 0 is sent as a tone with
// half-period T0 clocks, a 1 as a tone with half-period T1 clocks; every symbol
// lasts HALF_PERIODS_PER_BIT half-periods. Consecutive symbols continue from the
// current output level, so the waveform never jumps phase, and a symbol offered
// on the last clock of the previous one follows it with no gap.
//
// Optional feature macro: FSK_TONE_GENERATOR_STATS_EN
//   defined   -> f0_value / f1_value / unknown are free-running 32-bit tick
//                counters (clocks spent on the bit-0 tone, the bit-1 tone, and
//                enabled-but-idle), using the same split as the analyzer.
//   undefined -> no counter registers; the three outputs are tied to 0.
//
// Reset: 'clear' is asynchronous and active-low.
module fsk_tone_generator #(
   parameter int FREQUENCY0           = 9000,
   parameter int FREQUENCY1           = 11000,
   parameter int CLOCK_FREQUENCY      = 50000000,
   parameter int HALF_PERIODS_PER_BIT = 18
) (
   input  logic                       clock,
   input  logic                       clear,
   input  logic                       enable,
   fsk_tone_generator_if.slave        hs,
   output logic                       sample_data,
   output logic                       busy,
   output logic [31:0]                f0_value,
   output logic [31:0]                f1_value,
   output logic [31:0]                unknown
);

   // ------------------------------------------------------------------
   // Derived timing constants
   // ------------------------------------------------------------------
   // Half-period lengths in clocks. FREQUENCY0 < FREQUENCY1, so T0 >= T1,
   // and the design relies on T1 >= 2 (a one-clock half-period would make
   // the first clock of a symbol also its toggle clock).
   localparam int T0 = CLOCK_FREQUENCY / (2 * FREQUENCY0);
   localparam int T1 = CLOCK_FREQUENCY / (2 * FREQUENCY1);

   // tick_cnt only ever runs 0 .. T0-1, half_cnt only 0 .. HALF_PERIODS_PER_BIT-1.
   localparam int TICK_W = (T0 > 1) ? $clog2(T0) : 1;
   localparam int HALF_W = (HALF_PERIODS_PER_BIT > 1) ? $clog2(HALF_PERIODS_PER_BIT) : 1;

   localparam logic [TICK_W-1:0] T0_LAST   = TICK_W'(T0 - 1);
   localparam logic [TICK_W-1:0] T1_LAST   = TICK_W'(T1 - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_PERIODS_PER_BIT - 1);

   // ------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] TONE = 1'b1;

   logic [0:0]        state;
   logic              cur_bit;
   logic [TICK_W-1:0] tick_cnt;
   logic [HALF_W-1:0] half_cnt;

   logic              is_idle;
   logic              is_tone;
   logic              period_end;
   logic              last_clock;
   logic              handshake;

   // ------------------------------------------------------------------
   // Combinational status
   // ------------------------------------------------------------------
   assign is_idle = (state == IDLE);
   assign is_tone = (state == TONE);

   // The half-period length follows the bit currently being sent.
   assign period_end = (tick_cnt == (cur_bit ? T1_LAST : T0_LAST));

   // Final toggle clock of the symbol: the only clock inside TONE on which a
   // new symbol may be accepted without leaving the state.
   assign last_clock = is_tone && period_end && (half_cnt == HALF_LAST);

   // Ready depends only on enable, state and counters, never on bit_valid.
   // Gating with clear keeps it low while the block is held in reset.
   assign hs.bit_ready = clear && enable && (is_idle || last_clock);

   assign handshake = hs.bit_valid && hs.bit_ready;

   assign busy = is_tone;

   // ------------------------------------------------------------------
   // Transmitter: symbol acceptance, half-period timing and output toggling
   // ------------------------------------------------------------------
   // Drives the IDLE/TONE machine, the tick and half-period counters and the
   // square-wave output; an enable drop in TONE abandons the symbol but keeps
   // the output level so the line does not glitch.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state       <= IDLE;
         cur_bit     <= 1'b0;
         tick_cnt    <= '0;
         half_cnt    <= '0;
         sample_data <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  cur_bit  <= hs.bit_data;
                  tick_cnt <= '0;
                  half_cnt <= '0;
                  state    <= TONE;
               end
            end

            TONE: begin
               if (!enable) begin
                  tick_cnt <= '0;
                  half_cnt <= '0;
                  state    <= IDLE;
               end else if (period_end) begin
                  sample_data <= ~sample_data;
                  tick_cnt    <= '0;
                  if (half_cnt == HALF_LAST) begin
                     half_cnt <= '0;
                     if (handshake) begin
                        cur_bit <= hs.bit_data;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     half_cnt <= half_cnt + HALF_W'(1);
                  end
               end else begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef FSK_TONE_GENERATOR_STATS_EN
   // ------------------------------------------------------------------
   // Tick statistics
   // ------------------------------------------------------------------
   logic [31:0] f0_cnt;
   logic [31:0] f1_cnt;
   logic [31:0] unknown_cnt;

   // Per-clock classification of where the transmitter spent its time; the
   // counters wrap naturally at 2^32.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         f0_cnt      <= 32'd0;
         f1_cnt      <= 32'd0;
         unknown_cnt <= 32'd0;
      end else begin
         if (is_tone && !cur_bit) begin
            f0_cnt <= f0_cnt + 32'd1;
         end
         if (is_tone && cur_bit) begin
            f1_cnt <= f1_cnt + 32'd1;
         end
         if (is_idle && enable) begin
            unknown_cnt <= unknown_cnt + 32'd1;
         end
      end
   end

   assign f0_value = f0_cnt;
   assign f1_value = f1_cnt;
   assign unknown  = unknown_cnt;
`else
   assign f0_value = 32'd0;
   assign f1_value = 32'd0;
   assign unknown  = 32'd0;
`endif

endmodule
